// File: rtl/port_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: toggle-handshake request/ack on CPU
// output/input ports, LSB-first serialization, sticky overrun on early re-request.
module port_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic [7:0] tx_ctrl,
    output logic [7:0] tx_status,
    output logic       txd
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             txd_q, txd_d;
    logic             ack_q, ack_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;
    logic             req_q;

    logic req_bit;
    logic enable;
    logic ovr_clear;
    logic req_pending;
    logic bit_end;
    logic unused_ctrl;

    assign req_bit     = tx_ctrl[0];
    assign enable      = tx_ctrl[1];
    assign ovr_clear   = tx_ctrl[2];
    assign unused_ctrl = ^tx_ctrl[7:3];
    assign req_pending = (req_bit != ack_q);
    assign bit_end     = (cnt_q == CNT_LAST);

    // Next-state and next-output computation for every register.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        txd_d     = txd_q;
        ack_d     = ack_q;
        busy_d    = busy_q;
        overrun_d = overrun_q;

        case (state_q)
            IDLE: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
                if (req_pending && enable) begin
                    shreg_d   = tx_data;
                    state_d   = START;
                    txd_d     = 1'b0;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                    txd_d     = shreg_q[0];
                    shreg_d   = {1'b0, shreg_q[7:1]};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
                        state_d   = STOP;
                        txd_d     = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        txd_d     = shreg_q[0];
                        shreg_d   = {1'b0, shreg_q[7:1]};
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    ack_d   = ~ack_q;
                    busy_d  = 1'b0;
                    txd_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // A request edge seen while busy is lost; set beats clear.
        if (ovr_clear) begin
            overrun_d = 1'b0;
        end
        if (busy_q && (req_bit != req_q)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            txd_q     <= 1'b1;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            req_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            txd_q     <= txd_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            req_q     <= req_bit;
        end
    end

    assign txd       = txd_q;
    assign tx_status = {5'b0, overrun_q, ack_q, busy_q};

endmodule

// File: doc/port_uart_tx.md
PORT_UART_TX -- requirements
Module: port_uart_tx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, 16, clock cycles per serial bit; legal values >= 2.
REQ-002 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 SHALL have port: tx_data  input  8  byte to send; driven by a CPU memory-mapped output port.
REQ-005 SHALL have port: tx_ctrl  input  8  driven by a CPU output port; bit0 = req toggle, bit1 = enable, bit2 = overrun clear, bits 7:3 ignored.
REQ-006 SHALL have port: tx_status  output  8  feeds a CPU input port; bit0 = busy, bit1 = ack toggle, bit2 = overrun, bits 7:3 = 0.
REQ-007 SHALL have port: txd  output  1  serial line, 8N1, LSB first, idle high, registered.

Function
REQ-008 SHALL implement FSM states IDLE, START, DATA, STOP; busy = 1 in START, DATA and STOP, else 0.
REQ-009 SHALL treat a request as pending when tx_ctrl[0] != ack (toggle handshake).
REQ-010 SHALL, in IDLE, on an edge where the request is pending and tx_ctrl[1] = 1: latch tx_data into the shift register, enter START, drive txd = 0 from that edge.
REQ-011 SHALL keep each bit on txd for exactly CLKS_PER_BIT cycles: START (0), 8 DATA bits LSB first, STOP (1); frame = 10*CLKS_PER_BIT cycles.
REQ-012 SHALL, on the edge ending STOP: enter IDLE, invert ack, deassert busy.
REQ-013 SHALL ignore tx_data changes after latch; the frame in flight is unaffected.
REQ-014 SHALL gate frame start only by enable; deasserting enable mid-frame SHALL NOT abort the frame.
REQ-015 SHALL hold txd = 1 and not start when the request is pending and enable = 0.
REQ-016 SHALL start a new frame on the first edge after returning to IDLE if a request is still pending (minimum one idle cycle between frames).
REQ-017 SHALL register tx_ctrl[0] as req_q every cycle; if tx_ctrl[0] != req_q while busy, overrun SHALL set to 1 (sticky).
REQ-018 SHALL clear overrun on an edge where tx_ctrl[2] = 1; set SHALL win over a simultaneous clear.
REQ-019 SHALL use a bit-cycle counter of width clog2(CLKS_PER_BIT) and a bit index 0..7, both wrapping to 0 at each bit/frame boundary.

Reset
REQ-020 SHALL, while reset = 0 and independent of clk, force: state IDLE, txd = 1, ack = 0, overrun = 0, req_q = 0, counters 0, shift register 0; tx_status = 0x00.
REQ-021 SHALL abort any frame in flight on reset assertion; txd goes high immediately.
REQ-022 SHALL, after reset release with tx_ctrl[0] = 1 and enable = 1, start a frame on the first edge (request pending because ack = 0).

Verification (CLKS_PER_BIT = 4)
REQ-023 SHALL cover: tx_data = 0xA5, tx_ctrl 0x02 -> 0x03 -> txd = 0,1,0,1,0,0,1,0,1,1, each 4 cycles; tx_status bit1 = 1 and busy = 0 after 40 cycles.
REQ-024 SHALL cover: request pending with tx_ctrl = 0x01 (enable 0) for 100 cycles -> txd stays 1, tx_status = 0x00; set enable -> frame starts next edge.
REQ-025 SHALL cover: second toggle of tx_ctrl[0] at cycle 10 of a frame -> tx_status bit2 = 1 after next edge; tx_ctrl[2] = 1 -> bit2 = 0.
REQ-026 SHALL cover: reset = 0 at cycle 17 of a frame -> txd = 1, tx_status = 0x00 asynchronously; after release, no frame if tx_ctrl[0] = 0.
REQ-027 SHALL cover: tx_data changed from 0x3C to 0xFF during DATA -> serialized byte remains 0x3C.
REQ-028 SHALL cover: two back-to-back toggles, each issued after ack matches -> two frames of 40 cycles separated by exactly 1 idle-high cycle.
